// File: rtl/xfifo_prog_if.sv
// Bus bundle for xfifo_prog: write/read requests, control strobes, thresholds,
// read data and status. The producer/consumer side uses master, the FIFO uses slave.
interface xfifo_prog_if #(
  parameter int DATA_BITS = 10,
  parameter int ADDR_BITS = 3
);
  // Request semantics: a request is sampled on every posedge. It is acted on
  // only if the FIFO accepts it that cycle. Rejected requests raise the sticky
  // error flags. A read's data appears one cycle later, qualified by fifo_data_valid.
  logic [DATA_BITS-1:0] fifo_data_in;
  logic                 fifo_write;
  logic                 fifo_read;
  logic                 retorno;
  logic                 flush;
  logic                 err_clear;
  logic [ADDR_BITS:0]   high_limit;
  logic [ADDR_BITS:0]   low_limit;

  logic [DATA_BITS-1:0] fifo_data_out;
  logic                 fifo_data_valid;
  logic                 fifo_full_out;
  logic                 fifo_empty_out;
  logic                 fifo_almost_full_out;
  logic                 fifo_almost_empty_out;
  logic [ADDR_BITS:0]   fifo_count;
  logic                 error_overflow;
  logic                 error_underflow;

  modport master (
    output fifo_data_in, fifo_write, fifo_read, retorno, flush, err_clear,
           high_limit, low_limit,
    input  fifo_data_out, fifo_data_valid, fifo_full_out, fifo_empty_out,
           fifo_almost_full_out, fifo_almost_empty_out, fifo_count,
           error_overflow, error_underflow
  );

  modport slave (
    input  fifo_data_in, fifo_write, fifo_read, retorno, flush, err_clear,
           high_limit, low_limit,
    output fifo_data_out, fifo_data_valid, fifo_full_out, fifo_empty_out,
           fifo_almost_full_out, fifo_almost_empty_out, fifo_count,
           error_overflow, error_underflow
  );
endinterface

// File: rtl/xfifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// registered read data, flush, non-consuming re-read (retorno) and sticky errors.
module xfifo_prog #(
  parameter int DATA_BITS = 10,
  parameter int ADDR_BITS = 3
) (
  input logic        clk,
  input logic        reset,
  xfifo_prog_if.slave bus
);

  localparam int                 DEPTH     = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS + 1)'(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   count;
  logic [ADDR_BITS:0]   count_next;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 err_ovf;
  logic                 err_unf;

  logic full;
  logic empty;
  logic rd_ok;
  logic wr_ok;
  logic consume;
  logic ovf_set;
  logic unf_set;

  // Occupancy is tracked only by count; the pointers never decide full/empty.
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // A full FIFO can still take a write when a consuming read frees a slot.
  always_comb begin
    rd_ok   = bus.fifo_read && !empty;
    consume = rd_ok && !bus.retorno;
    wr_ok   = bus.fifo_write && (!full || consume);
    ovf_set = bus.fifo_write && !wr_ok && !bus.flush;
    unf_set = bus.fifo_read && !rd_ok && !bus.flush;
  end

  always_comb begin
    count_next = count;
    case ({wr_ok, consume})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_valid <= 1'b0;
    end else begin
      if (wr_ok)   wr_ptr <= wr_ptr + 1'b1;
      if (consume) rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      data_valid <= rd_ok;
      if (rd_ok) data_out <= mem[rd_ptr];
    end
  end

  // Storage has no reset; a same-cycle read of wr_ptr sees the old word.
  always_ff @(posedge clk) begin
    if (!reset && !bus.flush && wr_ok) mem[wr_ptr] <= bus.fifo_data_in;
  end

  // A new error in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (ovf_set)            err_ovf <= 1'b1;
      else if (bus.err_clear) err_ovf <= 1'b0;
      if (unf_set)            err_unf <= 1'b1;
      else if (bus.err_clear) err_unf <= 1'b0;
    end
  end

  assign bus.fifo_data_out         = data_out;
  assign bus.fifo_data_valid       = data_valid;
  assign bus.fifo_full_out         = full;
  assign bus.fifo_empty_out        = empty;
  assign bus.fifo_count            = count;
  assign bus.error_overflow        = err_ovf;
  assign bus.error_underflow       = err_unf;
  // A zero threshold falls back to the plain full/empty condition.
  assign bus.fifo_almost_full_out  = (bus.high_limit == '0) ? full  : (count >= bus.high_limit);
  assign bus.fifo_almost_empty_out = (bus.low_limit  == '0) ? empty : (count <= bus.low_limit);

endmodule

// File: tb/tb_xfifo_prog.sv
// Scoreboard bench for xfifo_prog (DATA_BITS=10, ADDR_BITS=3): a queue model
// predicts occupancy, flags and errors; read data is matched through exp_q.
module tb_xfifo_prog;
  localparam int DW    = 10;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk;
  logic reset;

  xfifo_prog_if #(.DATA_BITS(DW), .ADDR_BITS(AW)) bus ();

  xfifo_prog #(.DATA_BITS(DW), .ADDR_BITS(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state and scoreboard
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_data;
  logic          m_valid;
  logic          m_ovf;
  logic          m_unf;
  int            vectors;
  int            miscompares;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Predict the effect of the inputs currently driven, using pre-edge model state.
  task automatic model_step();
    int  cnt;
    bit  rd_ok, wr_ok, cons;
    cnt = mq.size();
    if (reset) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_valid = 0; last_data = '0;
    end else if (bus.flush) begin
      mq.delete();
      m_valid = 0;
      if (bus.err_clear) begin m_ovf = 0; m_unf = 0; end
    end else begin
      rd_ok = bus.fifo_read && (cnt != 0);
      cons  = rd_ok && !bus.retorno;
      wr_ok = bus.fifo_write && ((cnt < DEPTH) || cons);
      if (rd_ok) begin
        exp_q.push_back(mq[0]);
        last_data = mq[0];
        if (cons) void'(mq.pop_front());
      end
      if (wr_ok) mq.push_back(bus.fifo_data_in);
      if (bus.fifo_write && !wr_ok) m_ovf = 1;
      else if (bus.err_clear)       m_ovf = 0;
      if (bus.fifo_read && !rd_ok)  m_unf = 1;
      else if (bus.err_clear)       m_unf = 0;
      m_valid = rd_ok;
    end
  endtask

  task automatic check_outputs();
    int   cnt;
    logic af, ae;
    cnt = mq.size();
    af  = (bus.high_limit == 0) ? (cnt == DEPTH) : (cnt >= int'(bus.high_limit));
    ae  = (bus.low_limit  == 0) ? (cnt == 0)     : (cnt <= int'(bus.low_limit));
    check("count",        32'(bus.fifo_count),            32'(cnt));
    check("empty",        32'(bus.fifo_empty_out),        32'(cnt == 0));
    check("full",         32'(bus.fifo_full_out),         32'(cnt == DEPTH));
    check("almost_full",  32'(bus.fifo_almost_full_out),  32'(af));
    check("almost_empty", 32'(bus.fifo_almost_empty_out), 32'(ae));
    check("err_ovf",      32'(bus.error_overflow),        32'(m_ovf));
    check("err_unf",      32'(bus.error_underflow),       32'(m_unf));
    check("data_valid",   32'(bus.fifo_data_valid),       32'(m_valid));
    if (bus.fifo_data_valid) begin
      if (exp_q.size() == 0) check("unexpected_read", 32'(bus.fifo_data_out), 32'hFFFF_FFFF);
      else                   check("rd_data", 32'(bus.fifo_data_out), 32'(exp_q.pop_front()));
    end else begin
      check("data_hold", 32'(bus.fifo_data_out), 32'(last_data));
    end
  endtask

  // driver: apply one cycle of inputs, clock it, then compare.
  task automatic drive(input bit wr, input bit rd, input bit ret, input bit fl,
                       input bit clr, input logic [DW-1:0] d);
    bus.fifo_write   = wr;
    bus.fifo_read    = rd;
    bus.retorno      = ret;
    bus.flush        = fl;
    bus.err_clear    = clr;
    bus.fifo_data_in = d;
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, '0);
  endtask

  task automatic write_n(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, base + DW'(i));
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, '0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_ovf = 0; m_unf = 0; m_valid = 0; last_data = '0;
    reset = 1'b1;
    bus.high_limit = '0;
    bus.low_limit  = '0;
    drive(0, 0, 0, 0, 0, '0);
    drive(1, 1, 0, 0, 0, 10'h155);
    reset = 1'b0;

    // fill, then overflow attempt on a full FIFO
    write_n(8, 10'h001);
    drive(1, 0, 0, 0, 0, 10'h3FF);

    // drain, then underflow; data_out must hold 0x008
    read_n(8);
    idle();
    drive(0, 1, 0, 0, 0, '0);
    drive(0, 0, 0, 0, 1, '0);

    // full with simultaneous write/read: 0x2AA comes out last
    write_n(8, 10'h101);
    drive(1, 1, 0, 0, 0, 10'h2AA);
    read_n(8);
    idle();

    // retorno re-reads the head twice, then a consuming read
    write_n(3, 10'h0A0);
    drive(0, 1, 1, 0, 0, '0);
    drive(0, 1, 1, 0, 0, '0);
    drive(0, 1, 0, 0, 0, '0);
    drive(1, 0, 1, 0, 0, 10'h0B0);
    drive(0, 0, 1, 0, 0, '0);
    drive(0, 0, 0, 1, 0, '0);

    // empty FIFO with simultaneous write and read
    drive(1, 1, 0, 0, 0, 10'h0C3);
    drive(0, 1, 0, 0, 1, '0);
    idle();

    // programmable thresholds
    bus.high_limit = 4'd6;
    bus.low_limit  = 4'd2;
    idle();
    write_n(7, 10'h200);
    bus.high_limit = 4'd0;
    idle();
    drive(1, 0, 0, 0, 0, 10'h207);
    read_n(3);
    bus.high_limit = 4'd9;
    bus.low_limit  = 4'd12;
    idle();
    write_n(3, 10'h210);
    bus.high_limit = 4'd6;
    bus.low_limit  = 4'd2;

    // count 5 with overflow flagged, then flush with write+read
    drive(1, 0, 0, 0, 0, 10'h3AB);
    read_n(3);
    drive(1, 1, 0, 1, 0, 10'h3CD);
    idle();
    drive(0, 0, 0, 0, 1, '0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        bus.high_limit = 4'($urandom_range(0, 9));
        bus.low_limit  = 4'($urandom_range(0, 9));
      end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 40) == 0),
            ($urandom_range(0, 10) == 0), DW'($urandom_range(0, 1023)));
    end

    // reset in the middle of a write burst
    drive(0, 0, 0, 1, 0, '0);
    write_n(3, 10'h111);
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 10'h114);
    reset = 1'b0;
    write_n(2, 10'h120);
    read_n(3);
    idle();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
